float_triple_packer: RTL

FLOAT_TRIPLE_PACKER -- requirements
Module: float_triple_packer

---
 rtl/float_triple_packer.sv | 94 +++++++++
 1 files changed

// File: rtl/float_triple_packer.sv
// rtl/float_triple_packer.sv - groups accepted float words into triples and launches them to a sorter.
// A completed triple waits in a pending register; a one-cycle lockout separates consecutive launches.
module float_triple_packer #(
  parameter int FLEN = 64,
  parameter int NE   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [FLEN-1:0]      in_data,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic                 sort_busy,
  output logic                 out_valid,
  output logic [0:2][FLEN-1:0] out_unsorted,
  output logic                 out_special,
  output logic [15:0]          launch_cnt,
  output logic [15:0]          drop_cnt
);

  logic [1:0]            r_idx;
  logic [0:1][FLEN-1:0]  r_slot;
  logic [0:2][FLEN-1:0]  r_pend;
  logic                  r_pend_full;
  logic                  r_lockout;
  logic [15:0]           r_launch_cnt;
  logic [15:0]           r_drop_cnt;

  logic w_launch;
  logic w_ready;
  logic w_accept;
  logic w_complete;
  logic w_special;

  // Gating with rst keeps every strobe quiet during the reset cycle itself.
  assign w_launch   = !rst && r_pend_full && !sort_busy && !r_lockout;
  assign w_ready    = !rst && !flush && ((r_idx != 2'd2) || !r_pend_full || w_launch);
  assign w_accept   = in_valid && w_ready;
  assign w_complete = w_accept && (r_idx == 2'd2);

  always_comb begin
    w_special = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (&r_pend[s][FLEN-2 -: NE]) w_special = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= 2'd0;
      r_slot       <= '0;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_lockout    <= 1'b0;
      r_launch_cnt <= 16'd0;
      r_drop_cnt   <= 16'd0;
    end else begin
      r_lockout <= w_launch;
      if (w_launch) r_launch_cnt <= r_launch_cnt + 16'd1;

      if (flush) begin
        r_idx      <= 2'd0;
        r_drop_cnt <= r_drop_cnt + {14'd0, r_idx};
      end else if (w_accept) begin
        case (r_idx)
          2'd0: begin
            r_slot[0] <= in_data;
            r_idx     <= 2'd1;
          end
          2'd1: begin
            r_slot[1] <= in_data;
            r_idx     <= 2'd2;
          end
          default: begin
            r_pend <= {r_slot[0], r_slot[1], in_data};
            r_idx  <= 2'd0;
          end
        endcase
      end

      // A triple completing on the launch edge reloads pend and keeps it full.
      if (w_complete) r_pend_full <= 1'b1;
      else if (w_launch) r_pend_full <= 1'b0;
    end
  end

  assign in_ready     = w_ready;
  assign out_valid    = w_launch;
  assign out_unsorted = r_pend;
  assign out_special  = w_special && !rst;
  assign launch_cnt   = r_launch_cnt;
  assign drop_cnt     = r_drop_cnt;

endmodule
